// File: rtl/stream_packer.sv
// Packs RATIO input beats into one wide word (early close on i_last); registered output, 1-cycle latency.
// o_ready = !o_valid || i_ready: a held, back-pressured word stalls the input stream.
module stream_packer #(
   parameter int DWIDTH = 8,
   parameter int RATIO  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DWIDTH-1:0]        i_data,
   input  logic                     i_valid,
   input  logic                     i_last,
   output logic                     o_ready,
   output logic [RATIO*DWIDTH-1:0]  o_data,
   output logic [RATIO-1:0]         o_keep,
   output logic                     o_last,
   output logic                     o_valid,
   input  logic                     i_ready
);

   localparam int CW = $clog2(RATIO);

   logic [RATIO*DWIDTH-1:0] acc_q, acc_d;
   logic [RATIO-1:0]        keep_q, keep_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [RATIO*DWIDTH-1:0] data_q, data_d;
   logic [RATIO-1:0]        okeep_q, okeep_d;
   logic                    last_q, last_d;
   logic                    vld_q, vld_d;

   logic                    accept;
   logic                    complete;
   logic [RATIO-1:0]        lane_oh;
   logic [RATIO*DWIDTH-1:0] merged;

   assign o_ready  = !vld_q || i_ready;
   assign accept   = i_valid && o_ready;
   assign complete = (cnt_q == CW'(RATIO - 1)) || i_last;
   assign lane_oh  = {{(RATIO-1){1'b0}}, 1'b1} << cnt_q;

   // Current beat drops into lane cnt_q; lanes above it are forced to zero.
   always_comb begin
      merged = '0;
      for (int l = 0; l < RATIO; l++) begin
         if (l == int'(cnt_q))
            merged[l*DWIDTH +: DWIDTH] = i_data;
         else if (l < int'(cnt_q))
            merged[l*DWIDTH +: DWIDTH] = acc_q[l*DWIDTH +: DWIDTH];
      end
   end

   always_comb begin
      acc_d   = acc_q;
      keep_d  = keep_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      okeep_d = okeep_q;
      last_d  = last_q;
      vld_d   = vld_q;
      if (vld_q && i_ready)
         vld_d = 1'b0;
      if (accept) begin
         if (complete) begin
            data_d  = merged;
            okeep_d = keep_q | lane_oh;
            last_d  = i_last;
            vld_d   = 1'b1;
            acc_d   = '0;
            keep_d  = '0;
            cnt_d   = '0;
         end else begin
            acc_d   = merged;
            keep_d  = keep_q | lane_oh;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         keep_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         okeep_q <= '0;
         last_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         keep_q  <= keep_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         okeep_q <= okeep_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
      end
   end

   assign o_data  = data_q;
   assign o_keep  = okeep_q;
   assign o_last  = last_q;
   assign o_valid = vld_q;

endmodule

// File: tb/tb_stream_packer.sv
// Randomized and directed stimulus for stream_packer, checked against a queue-based packing model.
module tb_stream_packer;

   localparam int DW = 8;
   localparam int R  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   i_data = '0;
   logic            i_valid = 1'b0;
   logic            i_last = 1'b0;
   logic            i_ready = 1'b0;
   logic            o_ready;
   logic [R*DW-1:0] o_data;
   logic [R-1:0]    o_keep;
   logic            o_last;
   logic            o_valid;

   stream_packer #(.DWIDTH(DW), .RATIO(R)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
      .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
      .o_valid(o_valid), .i_ready(i_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            last;
      logic [R-1:0]    keep;
      logic [R*DW-1:0] dat;
   } word_t;

   int nvec = 0;
   int nerr = 0;

   // Model state: beats gathered so far for the open word, and words completed but not yet consumed.
   logic [DW-1:0] cur_beats[$];
   word_t         exp_q[$];
   word_t         got_hist[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic word_t build_word(input logic lst);
      word_t w;
      w = '0;
      for (int b = 0; b < cur_beats.size(); b++) begin
         w.dat[b*DW +: DW] = cur_beats[b];
         w.keep[b] = 1'b1;
      end
      w.last = lst;
      return w;
   endfunction

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic r, input logic rs);
      logic mvld;
      logic mrdy;
      @(posedge clk);
      #1;
      rst = rs; i_valid = v; i_data = d; i_last = l; i_ready = r;
      @(negedge clk);
      mvld = (exp_q.size() != 0);
      mrdy = !mvld || r;
      chk("o_valid", 64'(o_valid), 64'(mvld));
      chk("o_ready", 64'(o_ready), 64'(mrdy));
      if (mvld) begin
         chk("o_data", 64'(o_data), 64'(exp_q[0].dat));
         chk("o_keep", 64'(o_keep), 64'(exp_q[0].keep));
         chk("o_last", 64'(o_last), 64'(exp_q[0].last));
      end
      if (rs) begin
         cur_beats.delete();
         exp_q.delete();
      end else begin
         if (mvld && r) begin
            void'(exp_q.pop_front());
            got_hist.push_back(word_t'{o_last, o_keep, o_data});
         end
         if (v && mrdy) begin
            cur_beats.push_back(d);
            if (cur_beats.size() == R || l) begin
               exp_q.push_back(build_word(l));
               cur_beats.delete();
            end
         end
      end
   endtask

   initial begin
      int base;
      logic [DW-1:0] bt;
      word_t w;

      // Reset and reset-state checks
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 0);
      chk("rst_o_data", 64'(o_data), 64'h0);
      chk("rst_o_keep", 64'(o_keep), 64'h0);
      chk("rst_o_last", 64'(o_last), 64'h0);
      chk("rst_o_ready", 64'(o_ready), 64'h1);

      // Full word, back-to-back
      base = got_hist.size();
      cyc(1, 8'h11, 0, 1, 0); cyc(1, 8'h22, 0, 1, 0);
      cyc(1, 8'h33, 0, 1, 0); cyc(1, 8'h44, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0); cyc(0, 8'h00, 0, 1, 0);
      chk("t1_count", 64'(got_hist.size() - base), 64'd1);
      w = got_hist[base];
      chk("t1_data", 64'(w.dat), 64'h44332211);
      chk("t1_keep", 64'(w.keep), 64'hF);
      chk("t1_last", 64'(w.last), 64'h0);

      // Early close after two beats, then a single-beat word from lane 0
      base = got_hist.size();
      cyc(1, 8'hAA, 0, 1, 0); cyc(1, 8'hBB, 1, 1, 0);
      cyc(1, 8'h5A, 1, 1, 0);
      cyc(0, 8'h00, 0, 1, 0); cyc(0, 8'h00, 0, 1, 0);
      chk("t2_count", 64'(got_hist.size() - base), 64'd2);
      w = got_hist[base];
      chk("t2_data", 64'(w.dat), 64'h0000BBAA);
      chk("t2_keep", 64'(w.keep), 64'h3);
      chk("t2_last", 64'(w.last), 64'h1);
      w = got_hist[base+1];
      chk("t3_data", 64'(w.dat), 64'h0000005A);
      chk("t3_keep", 64'(w.keep), 64'h1);
      chk("t3_last", 64'(w.last), 64'h1);

      // i_last on the final lane gives a full mask with o_last set
      base = got_hist.size();
      cyc(1, 8'hC1, 0, 1, 0); cyc(1, 8'hC2, 0, 1, 0);
      cyc(1, 8'hC3, 0, 1, 0); cyc(1, 8'hC4, 1, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      chk("tl_keep", 64'(got_hist[base].keep), 64'hF);
      chk("tl_last", 64'(got_hist[base].last), 64'h1);

      // Continuous stream at full rate
      base = got_hist.size();
      for (int i = 0; i < 32; i++) cyc(1, DW'(i), 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      chk("t4_count", 64'(got_hist.size() - base), 64'd8);
      chk("t4_first", 64'(got_hist[base].dat), 64'h03020100);
      chk("t4_lastw", 64'(got_hist[base+7].dat), 64'h1F1E1D1C);

      // Held word under backpressure with input pending
      base = got_hist.size();
      cyc(1, 8'h11, 0, 1, 0); cyc(1, 8'h22, 0, 1, 0);
      cyc(1, 8'h33, 0, 1, 0); cyc(1, 8'h44, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'h55, 0, 0, 0);
         chk("t5_hold_rdy", 64'(o_ready), 64'h0);
         chk("t5_hold_dat", 64'(o_data), 64'h44332211);
      end
      cyc(1, 8'h55, 0, 1, 0); cyc(1, 8'h66, 0, 1, 0);
      cyc(1, 8'h77, 0, 1, 0); cyc(1, 8'h88, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      chk("t5_count", 64'(got_hist.size() - base), 64'd2);
      chk("t5_w0", 64'(got_hist[base].dat), 64'h44332211);
      chk("t5_w1", 64'(got_hist[base+1].dat), 64'h88776655);

      // Reset in the middle of a partial word
      base = got_hist.size();
      cyc(1, 8'h01, 0, 1, 0); cyc(1, 8'h02, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 1);
      cyc(1, 8'h10, 0, 1, 0); cyc(1, 8'h20, 0, 1, 0);
      cyc(1, 8'h30, 0, 1, 0); cyc(1, 8'h40, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0); cyc(0, 8'h00, 0, 1, 0);
      chk("t6_count", 64'(got_hist.size() - base), 64'd1);
      chk("t6_data", 64'(got_hist[base].dat), 64'h40302010);
      chk("t6_keep", 64'(got_hist[base].keep), 64'hF);

      // Random traffic with random backpressure and early closes
      for (int i = 0; i < 3000; i++) begin
         bt = DW'($urandom);
         cyc(($urandom_range(0, 3) != 0), bt, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0), 1'b0);
      end
      for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Valid-ready width upsizer that sits directly downstream of the skid buffer.
- Collects RATIO consecutive DWIDTH-bit beats into one RATIO*DWIDTH-bit word, with per-lane keep bits and an early-close (i_last) path for partial words.
- Output stage is registered, so downstream sees clean, stable, registered data/valid.

Parameters:
- DWIDTH, 8, input beat width in bits (>=1).
- RATIO, 4, beats packed per output word (>=2). Counter width is clog2(RATIO).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  DWIDTH  input beat.
- i_valid  input  1  input beat valid.
- i_last  input  1  beat closes the current word early; qualified by i_valid.
- o_ready  output  1  ready to upstream (skid buffer's i_ready).
- o_data  output  RATIO*DWIDTH  packed word; beat 0 in bits [DWIDTH-1:0].
- o_keep  output  RATIO  bit k = lane k holds a valid beat.
- o_last  output  1  word was closed by i_last.
- o_valid  output  1  packed word valid.
- i_ready  input  1  downstream ready.

Behaviour:
- State registers:
  - accumulator acc_rg (RATIO*DWIDTH), lane mask keep_acc (RATIO), counter cnt_rg (0..RATIO-1);
  - output registers o_data, o_keep, o_last, o_valid.
- Reset (rst=1 at posedge):
  - cnt_rg=0, acc_rg=0, keep_acc=0;
  - o_valid=0, o_data=0, o_keep=0, o_last=0.
  - o_ready reads 1 in the cycle after reset.
  - A partial word in progress when reset asserts is discarded, never emitted.
- Handshakes:
  - Input beat accepted on posedge when i_valid && o_ready.
  - Output word consumed on posedge when o_valid && i_ready.
- o_ready = !o_valid || i_ready, purely combinational.
  - It does not depend on i_valid, i_data or i_last.
  - It is low whenever a held word is back-pressured, even if the next beat would not complete a word.
- Accepted beat with cnt_rg=k that does not complete the word:
  - lane k of acc_rg <= i_data; keep_acc[k] <= 1; cnt_rg <= k+1.
- Accepted beat completes the word when cnt_rg==RATIO-1 or i_last=1. On that edge:
  - o_data <= acc_rg with lane k replaced by i_data, all lanes above k forced to 0.
  - o_keep <= keep_acc | (1<<k).
  - o_last <= i_last; o_valid <= 1.
  - acc_rg <= 0, keep_acc <= 0, cnt_rg <= 0.
- Latency: the completed word is visible on o_valid one cycle after the completing beat is accepted.
- Output hold: while o_valid && !i_ready, o_data, o_keep and o_last are stable and o_valid stays 1.
- Output consumed with no completing beat on the same edge: o_valid <= 0. o_data, o_keep and o_last may retain their old values.
- Simultaneous events:
  - Output consumed and completing beat accepted on the same edge: the new word loads and o_valid stays 1.
  - Result is no bubble: with i_ready tied 1, one word per RATIO input beats at full input rate.
- i_last boundaries:
  - i_last at cnt_rg==RATIO-1 produces a full keep mask with o_last=1.
  - i_last at cnt_rg==0 produces a single-lane word.
- i_last and i_data are ignored when i_valid=0. No beat is ever dropped or duplicated.
- The o_ready-to-i_ready path is combinational. The registered o_ready of the upstream skid buffer terminates it.

Test Plan:
All scenarios use DWIDTH=8, RATIO=4.
1. Beats 0x11,0x22,0x33,0x44 back-to-back, i_last=0, i_ready=1 -> one cycle after the 4th accept: o_valid=1 for 1 cycle, o_data=0x44332211, o_keep=4'b1111, o_last=0.
2. Beats 0xAA, then 0xBB with i_last=1 -> o_data=0x0000BBAA, o_keep=4'b0011, o_last=1; the next word starts at lane 0.
3. Single beat 0x5A with i_last=1 at cnt_rg=0 -> o_data=0x0000005A, o_keep=4'b0001, o_last=1.
4. 32 beats 0x00..0x1F continuous with i_ready=1 -> o_ready constant 1, 8 words, first 0x03020100, last 0x1F1E1D1C, o_valid high exactly every 4th cycle, no bubbles.
5. Word 0x44332211 held with i_ready=0 for 5 cycles while i_valid=1 -> o_ready=0, output stable for all 5 cycles; i_ready then 1 -> word consumed once, stream resumes with no loss or duplication.
6. After 2 beats 0x01,0x02, pulse rst for 1 cycle, then send 0x10,0x20,0x30,0x40 -> o_valid stays 0 through reset, the only word out is 0x40302010 with keep 4'b1111.
